// File: rtl/atm_session_ctrl.sv
// ATM card-session sequencer: PIN check with retry/retain, amount entry, balance check,
// dispenser handshake and idle timeout. Define ATM_FAST_CASH_EN to enable D/E/F fast-cash keys.
module atm_session_ctrl #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned BAL_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             card_in,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic [15:0]      pin_ref,
  input  logic [BAL_W-1:0] balance,
  input  logic             disp_ack,
  output logic             disp_req,
  output logic [AMT_W-1:0] disp_amount,
  output logic             bal_dec,
  output logic             card_eject,
  output logic             card_retain,
  output logic [2:0]       state_o,
  output logic [1:0]       err_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PIN      = 3'd1,
    S_CHECK    = 3'd2,
    S_AMOUNT   = 3'd3,
    S_VERIFY   = 3'd4,
    S_DISPENSE = 3'd5,
    S_EJECT    = 3'd6,
    S_RETAIN   = 3'd7
  } state_t;

  localparam int unsigned   TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    TRIES_LIM = 3'(MAX_TRIES);
  localparam int unsigned   CW        = AMT_W + 4;
  localparam logic [CW-1:0] AMT_MAX   = {4'b0000, {AMT_W{1'b1}}};
  localparam int unsigned   XW        = (AMT_W > BAL_W) ? AMT_W : BAL_W;
  localparam logic [3:0]    KEY_ENTER  = 4'hA;
  localparam logic [3:0]    KEY_CANCEL = 4'hB;
  localparam logic [3:0]    KEY_CLEAR  = 4'hC;

`ifdef ATM_FAST_CASH_EN
  localparam int unsigned AMT_LIM = (1 << AMT_W) - 1;

  function automatic logic [AMT_W-1:0] fc_sat(input int unsigned v);
    return (v > AMT_LIM) ? {AMT_W{1'b1}} : AMT_W'(v);
  endfunction
`endif

  state_t            r_state, w_state;
  logic              r_card_d;
  logic [2:0]        r_tries, w_tries;
  logic [2:0]        r_cnt, w_cnt;
  logic [15:0]       r_buf, w_buf;
  logic [AMT_W-1:0]  r_amt, w_amt;
  logic [TW-1:0]     r_timer, w_timer;
  logic [1:0]        r_err, w_err;
  logic              r_disp_req, w_disp_req;
  logic [AMT_W-1:0]  r_disp_amount, w_disp_amount;
  logic              r_bal_dec, w_bal_dec;
  logic              r_eject, w_eject;
  logic              r_retain, w_retain;

  logic              w_is_digit;
  logic [CW-1:0]     w_amt_calc;
  logic              w_amt_fit;
  logic              w_over;

  assign w_is_digit = (key_code <= 4'd9);
  // Widened so that the overflow of amt*10+d is visible before truncation.
  assign w_amt_calc = {4'b0000, r_amt} * CW'(10) + CW'(key_code);
  assign w_amt_fit  = (w_amt_calc <= AMT_MAX);
  assign w_over     = (XW'(r_amt) > XW'(balance));

  always_comb begin
    w_state       = r_state;
    w_tries       = r_tries;
    w_cnt         = r_cnt;
    w_buf         = r_buf;
    w_amt         = r_amt;
    w_timer       = '0;
    w_err         = r_err;
    w_disp_req    = r_disp_req;
    w_disp_amount = r_disp_amount;
    w_bal_dec     = 1'b0;
    w_eject       = 1'b0;
    w_retain      = 1'b0;
    case (r_state)
      S_IDLE: if (card_in && !r_card_d) w_state = S_PIN;
      S_PIN: begin
        w_timer = r_timer + TW'(1);
        if (!card_in) w_state = S_IDLE;
        else if (key_valid) begin
          w_timer = '0;
          if (w_is_digit) begin
            if (r_cnt < 3'd4) begin
              w_buf = {r_buf[11:0], key_code};
              w_cnt = r_cnt + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            w_buf = '0;
            w_cnt = '0;
          end else if (key_code == KEY_ENTER)  w_state = S_CHECK;
          else if (key_code == KEY_CANCEL)     w_state = S_EJECT;
        end else if (r_timer == TMO_LAST) begin
          w_state = S_EJECT;
          w_err   = 2'd3;
        end
      end
      S_CHECK: begin
        if ((r_cnt == 3'd4) && (r_buf == pin_ref)) begin
          w_state = S_AMOUNT;
          w_tries = '0;
          w_err   = 2'd0;
        end else begin
          w_tries = r_tries + 3'd1;
          w_err   = 2'd1;
          w_buf   = '0;
          w_cnt   = '0;
          w_state = (w_tries == TRIES_LIM) ? S_RETAIN : S_PIN;
        end
      end
      S_AMOUNT: begin
        w_timer = r_timer + TW'(1);
        if (!card_in) w_state = S_IDLE;
        else if (key_valid) begin
          w_timer = '0;
          if (w_is_digit) begin
            if (w_amt_fit) w_amt = w_amt_calc[AMT_W-1:0];
          end else if (key_code == KEY_CLEAR) w_amt = '0;
          else if (key_code == KEY_ENTER) begin
            if (r_amt != '0) w_state = S_VERIFY;
          end else if (key_code == KEY_CANCEL) w_state = S_EJECT;
`ifdef ATM_FAST_CASH_EN
          else begin
            case (key_code)
              4'hD:    w_amt = fc_sat(20);
              4'hE:    w_amt = fc_sat(50);
              default: w_amt = fc_sat(100);
            endcase
            w_state = S_VERIFY;
          end
`endif
        end else if (r_timer == TMO_LAST) begin
          w_state = S_EJECT;
          w_err   = 2'd3;
        end
      end
      S_VERIFY: begin
        if (w_over) begin
          w_err   = 2'd2;
          w_state = S_EJECT;
        end else begin
          w_state       = S_DISPENSE;
          w_disp_req    = 1'b1;
          w_disp_amount = r_amt;
        end
      end
      S_DISPENSE: begin
        if (disp_ack) begin
          w_disp_req = 1'b0;
          w_bal_dec  = 1'b1;
          w_state    = S_EJECT;
        end
      end
      S_EJECT:  if (!card_in) w_state = S_IDLE;
      S_RETAIN: w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase
    // Session context is wiped on entry to IDLE so err_o reads 0 in the first IDLE cycle.
    if (w_state != r_state) w_timer = '0;
    if (w_state == S_IDLE) begin
      w_err   = '0;
      w_tries = '0;
      w_cnt   = '0;
      w_buf   = '0;
      w_amt   = '0;
    end
    if ((w_state == S_EJECT) && (r_state != S_EJECT)) w_eject = 1'b1;
    if (w_state == S_RETAIN) w_retain = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_card_d      <= 1'b0;
      r_tries       <= '0;
      r_cnt         <= '0;
      r_buf         <= '0;
      r_amt         <= '0;
      r_timer       <= '0;
      r_err         <= '0;
      r_disp_req    <= 1'b0;
      r_disp_amount <= '0;
      r_bal_dec     <= 1'b0;
      r_eject       <= 1'b0;
      r_retain      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_card_d      <= card_in;
      r_tries       <= w_tries;
      r_cnt         <= w_cnt;
      r_buf         <= w_buf;
      r_amt         <= w_amt;
      r_timer       <= w_timer;
      r_err         <= w_err;
      r_disp_req    <= w_disp_req;
      r_disp_amount <= w_disp_amount;
      r_bal_dec     <= w_bal_dec;
      r_eject       <= w_eject;
      r_retain      <= w_retain;
    end
  end

  assign disp_req    = r_disp_req;
  assign disp_amount = r_disp_amount;
  assign bal_dec     = r_bal_dec;
  assign card_eject  = r_eject;
  assign card_retain = r_retain;
  assign state_o     = r_state;
  assign err_o       = r_err;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed self-checking bench for atm_session_ctrl (default parameters).
module tb_atm_session_ctrl;

  logic        clock;
  logic        reset;
  logic        card_in;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] pin_ref;
  logic [15:0] balance;
  logic        disp_ack;
  logic        disp_req;
  logic [7:0]  disp_amount;
  logic        bal_dec;
  logic        card_eject;
  logic        card_retain;
  logic [2:0]  state_o;
  logic [1:0]  err_o;

  int checks;
  int failures;

  atm_session_ctrl #(
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(1000),
    .AMT_W      (8),
    .BAL_W      (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .card_in    (card_in),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .pin_ref    (pin_ref),
    .balance    (balance),
    .disp_ack   (disp_ack),
    .disp_req   (disp_req),
    .disp_amount(disp_amount),
    .bal_dec    (bal_dec),
    .card_eject (card_eject),
    .card_retain(card_retain),
    .state_o    (state_o),
    .err_o      (err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_good_pin();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    card_in   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    pin_ref   = 16'h1234;
    balance   = 16'd100;
    disp_ack  = 1'b0;
    tick(); tick();
    chk("rst_state", state_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", disp_req, 0);
    chk("rst_amount", disp_amount, 0);
    chk("rst_pulses", {bal_dec, card_eject, card_retain}, 0);
    reset = 1'b1;
    tick();

    // Normal withdrawal of 50
    card_in = 1'b1; tick();
    chk("t1_pin", state_o, 1);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    chk("t1_check", state_o, 2);
    tick();
    chk("t1_amount", state_o, 3);
    chk("t1_err", err_o, 0);
    press(4'h5); press(4'h0); press(4'hA);
    chk("t1_verify", state_o, 4);
    tick();
    chk("t1_disp_state", state_o, 5);
    chk("t1_req", disp_req, 1);
    chk("t1_amt", disp_amount, 50);
    tick();
    chk("t1_req_hold", disp_req, 1);
    chk("t1_no_dec", bal_dec, 0);
    tick();
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("t1_eject_state", state_o, 6);
    chk("t1_req_drop", disp_req, 0);
    chk("t1_bal_dec", bal_dec, 1);
    chk("t1_eject", card_eject, 1);
    tick();
    chk("t1_dec_pulse", {bal_dec, card_eject}, 0);
    chk("t1_wait_card", state_o, 6);
    card_in = 1'b0; tick();
    chk("t1_idle", state_o, 0);
    chk("t1_err_end", err_o, 0);

    // Three wrong PINs -> retain
    card_in = 1'b1; tick();
    for (int a = 1; a <= 3; a++) begin
      press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'hA);
      tick();
      if (a < 3) begin
        chk("t2_back_pin", state_o, 1);
        chk("t2_err1", err_o, 1);
      end else begin
        chk("t2_retain_state", state_o, 7);
        chk("t2_retain", card_retain, 1);
      end
    end
    tick();
    chk("t2_idle", state_o, 0);
    chk("t2_retain_pulse", card_retain, 0);
    chk("t2_err_clr", err_o, 0);
    card_in = 1'b0; tick();

    // Insufficient funds
    balance = 16'd150;
    card_in = 1'b1; tick();
    enter_good_pin();
    press(4'h2); press(4'h0); press(4'h0); press(4'hA);
    chk("t3_verify", state_o, 4);
    tick();
    chk("t3_eject_state", state_o, 6);
    chk("t3_err2", err_o, 2);
    chk("t3_eject", card_eject, 1);
    chk("t3_no_req", disp_req, 0);
    card_in = 1'b0; tick();
    chk("t3_idle", state_o, 0);

    // Clear and 5th digit in PIN, then timeout in AMOUNT
    card_in = 1'b1; tick();
    press(4'h9); press(4'hC);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'hA);
    tick();
    chk("t4_pin_ok", state_o, 3);
    repeat (999) tick();
    chk("t4_pre_tmo", state_o, 3);
    tick();
    chk("t4_tmo_state", state_o, 6);
    chk("t4_err3", err_o, 3);
    chk("t4_tmo_eject", card_eject, 1);
    card_in = 1'b0; tick();

    // Key on the expiry cycle, clear/enter-zero, amount saturation
    card_in = 1'b1; tick();
    enter_good_pin();
    repeat (999) tick();
    press(4'h1);
    chk("t5_key_wins", state_o, 3);
    chk("t5_key_err", err_o, 0);
    press(4'hC);
    press(4'h1); press(4'h2); press(4'h3); press(4'hC); press(4'hA);
    chk("t5_enter_zero", state_o, 3);
    press(4'h2); press(4'h5); press(4'h5); press(4'h9); press(4'hA);
    chk("t5_verify", state_o, 4);
    balance = 16'd300;
    tick();
    chk("t5_dispense", state_o, 5);
    chk("t5_amt255", disp_amount, 255);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("t5_bal_dec", bal_dec, 1);
    card_in = 1'b0; tick();

    // Card pulled mid-PIN, with a simultaneous Enter key
    card_in = 1'b1; tick();
    press(4'h1); press(4'h2);
    key_valid = 1'b1; key_code = 4'hA; card_in = 1'b0;
    tick();
    key_valid = 1'b0;
    chk("t6_idle", state_o, 0);
    chk("t6_no_eject", card_eject, 0);
    tick();
    chk("t6_no_eject2", card_eject, 0);

    // Reset during DISPENSE
    balance = 16'd100;
    card_in = 1'b1; tick();
    enter_good_pin();
    press(4'h3); press(4'h0); press(4'hA);
    tick();
    chk("t7_req", disp_req, 1);
    chk("t7_amt", disp_amount, 30);
    #2 reset = 1'b0;
    #1;
    chk("t7_async_req", disp_req, 0);
    chk("t7_async_state", state_o, 0);
    card_in = 1'b0;
    reset = 1'b1;
    tick();
    chk("t7_no_dec", bal_dec, 0);
    chk("t7_idle", state_o, 0);

    // Fast-cash key E
    card_in = 1'b1; tick();
    enter_good_pin();
    press(4'hE);
`ifdef ATM_FAST_CASH_EN
    chk("t8_fc_verify", state_o, 4);
    tick();
    chk("t8_fc_disp", state_o, 5);
    chk("t8_fc_amt", disp_amount, 50);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("t8_fc_eject", state_o, 6);
`else
    chk("t8_e_ignored", state_o, 3);
    press(4'hB);
    chk("t8_cancel", state_o, 6);
    chk("t8_cancel_eject", card_eject, 1);
`endif
    card_in = 1'b0; tick();
    chk("t8_idle", state_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Session sequencer for the virtual ATM. Runs one card session from insertion to card return:
  - PIN entry and check with retry limit and card retention,
  - withdrawal amount entry and balance check,
  - cash dispenser handshake, idle timeout.
- Sits between the keypad decoder and the dispenser/account datapath; exports its state code for the display FSM.

Parameters:
- MAX_TRIES, 3, wrong-PIN attempts before the card is retained (1..7).
- TIMEOUT_CYC, 1000, idle cycles allowed in PIN/AMOUNT before forced eject.
- AMT_W, 8, width of withdrawal amount (units).
- BAL_W, 16, width of account balance.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- card_in  in  1  level, card present.
- key_valid  in  1  single-cycle key strobe.
- key_code  in  4  0-9 digit, A enter, B cancel, C clear, D/E/F fast-cash (optional).
- pin_ref  in  16  reference PIN, 4 BCD digits, first-entered digit in [15:12].
- balance  in  BAL_W  current account balance, sampled in VERIFY.
- disp_ack  in  1  dispenser done.
- disp_req  out  1  dispense request, held until ack.
- disp_amount  out  AMT_W  amount to dispense, stable while disp_req=1.
- bal_dec  out  1  one-cycle pulse: commit debit of disp_amount.
- card_eject  out  1  one-cycle pulse.
- card_retain  out  1  one-cycle pulse.
- state_o  out  3  current state code.
- err_o  out  2  0 none, 1 wrong PIN, 2 insufficient funds, 3 timeout.

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, tries=0, digit count=0, amount=0, timer=0.
- States: IDLE=0, PIN=1, CHECK=2, AMOUNT=3, VERIFY=4, DISPENSE=5, EJECT=6, RETAIN=7. Registered Moore outputs; state_o mirrors state.
- IDLE:
  - Rising edge of card_in → PIN.
  - Clear err_o, tries, digit buffer and amount.
- PIN:
  - Digit shifts into 16-bit buffer while count<4; 5th and later digits are ignored.
  - C clears buffer and count.
  - A → CHECK.
  - B → EJECT.
- CHECK (1 cycle):
  - Match requires count==4 and buffer==pin_ref → AMOUNT, tries=0, err_o=0.
  - Otherwise tries+1. If the new tries==MAX_TRIES → RETAIN; else → PIN with err_o=1 and buffer cleared.
- AMOUNT:
  - Digit: amt=amt*10+d. If the result exceeds 2^AMT_W-1, the digit is ignored.
  - C clears amt.
  - A with amt==0 is ignored; A with amt!=0 → VERIFY.
  - B → EJECT.
- VERIFY (1 cycle):
  - amt>balance (zero-extended compare) → err_o=2, EJECT.
  - Otherwise → DISPENSE; disp_amount=amt and disp_req=1 from the next cycle.
- DISPENSE:
  - disp_req held high until disp_ack=1.
  - On the ack cycle: disp_req=0 next cycle, bal_dec pulses one cycle, → EJECT.
  - Keys, card_in and timeout are ignored in this state.
- EJECT:
  - card_eject pulses on the first cycle in state.
  - Remain until card_in=0, then → IDLE.
- RETAIN: card_retain pulses one cycle, → IDLE. card_in is ignored.
- Timeout (PIN/AMOUNT only):
  - Timer clears on state entry and on every key_valid; otherwise increments.
  - At TIMEOUT_CYC-1 → EJECT, err_o=3.
  - If key_valid and expiry occur in the same cycle, the key wins.
- card_in=0 while in PIN/AMOUNT → IDLE immediately, no eject pulse; this takes priority over key and timeout.
- key_valid in CHECK, VERIFY, EJECT, RETAIN, IDLE is ignored.
- err_o holds until the next IDLE entry or the next successful CHECK.
- Reset mid-DISPENSE aborts the session: disp_req drops asynchronously and there is no bal_dec.

Optional Feature:
- Macro ATM_FAST_CASH_EN.
- Defined: in AMOUNT, keys D/E/F load amt=20/50/100 (saturated to 2^AMT_W-1) and go directly → VERIFY.
- Undefined: D/E/F are ignored in every state; no extra logic.

Test Plan:
- pin_ref=16'h1234, card_in↑, keys 1,2,3,4,A, then 5,0,A, balance=100, disp_ack 3 cycles after req → disp_amount=50, bal_dec one pulse, card_eject pulse, IDLE after card_in=0, err_o=0.
- Wrong PIN 9,9,9,9,A three times with MAX_TRIES=3 → err_o=1 after attempts 1 and 2, card_retain pulse after attempt 3, state IDLE.
- Correct PIN, amount 2,0,0,A with balance=150 → err_o=2, card_eject pulse, disp_req never asserted.
- Correct PIN, no keys for TIMEOUT_CYC cycles in AMOUNT → err_o=3, EJECT. Repeat with a key on the expiry cycle → stays in AMOUNT.
- AMT_W=8: digits 2,5,5,9 → amt=255, 9 ignored. Keys 1,2,3,C,A → A ignored, stays AMOUNT. card_in=0 mid-PIN → IDLE with no eject pulse.
- With ATM_FAST_CASH_EN: after the correct PIN, key E → VERIFY, disp_amount=50. Without the macro: key E leaves the state unchanged.
